// File: rtl/pid_sched_pkg.sv
// rtl/pid_sched_pkg.sv - shared state encoding, default widths and lane-slice helper for the PID loop scheduler
package pid_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  localparam int PID_DATA_W  = 8;
  localparam int PID_TIMEOUT = 15;
  localparam int PID_MAX_CH  = 16;
  localparam int PID_IDX_W   = 4;
  localparam int PID_BUS_W   = PID_MAX_CH * PID_DATA_W;

  // Callers zero-extend their packed bus to PID_BUS_W so one helper serves any channel count up to PID_MAX_CH.
  function automatic logic [PID_DATA_W-1:0] lane_of(input logic [PID_BUS_W-1:0] bus,
                                                    input logic [PID_IDX_W-1:0] idx);
    return bus[idx*PID_DATA_W +: PID_DATA_W];
  endfunction

endpackage

// File: rtl/pid_rr_arbiter.sv
// rtl/pid_rr_arbiter.sv - combinational round-robin grant over pending channels
// Optional PID_SCHED_PRIO0_EN gives channel 0 absolute priority without moving the pointer.
module pid_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] pending_i,
  input  logic [CH_W-1:0]   rr_ptr_i,
  output logic [CH_W-1:0]   grant_o,
  output logic              any_pending_o,
  output logic              ptr_upd_o
);

  int idx;

  always_comb begin
    grant_o       = '0;
    idx           = 0;
    any_pending_o = |pending_i;
    ptr_upd_o     = |pending_i;
    // Scan farthest-first so the closest pending channel after the pointer wins.
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(rr_ptr_i) + k) % NUM_CH;
      if (pending_i[idx]) begin
        grant_o = CH_W'(idx);
      end
    end
`ifdef PID_SCHED_PRIO0_EN
    if (pending_i[0]) begin
      grant_o   = '0;
      ptr_upd_o = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/pid_loop_scheduler.sv
// rtl/pid_loop_scheduler.sv - time-multiplexes one PID core across NUM_CH loops with start/done handshake
// Build option PID_SCHED_PRIO0_EN: channel 0 granted ahead of the round-robin order.
module pid_loop_scheduler
  import pid_sched_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int DATA_W  = PID_DATA_W,
  parameter int TIMEOUT = PID_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*DATA_W-1:0] ch_setpoint,
  input  logic [NUM_CH*DATA_W-1:0] ch_feedback,
  output logic                     core_start,
  output logic [CH_W-1:0]          core_ch,
  output logic [DATA_W-1:0]        core_setpoint,
  output logic [DATA_W-1:0]        core_feedback,
  input  logic                     core_done,
  input  logic [DATA_W-1:0]        core_result,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic [DATA_W-1:0]        out_data,
  output logic [NUM_CH-1:0]        timeout_err,
  output logic                     busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [CH_W-1:0]     rr_ptr_q;
  logic [CH_W-1:0]     core_ch_q;
  logic [DATA_W-1:0]   core_sp_q, core_fb_q;
  logic [CH_W-1:0]     out_ch_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [NUM_CH-1:0]   timeout_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [CH_W-1:0]     grant;
  logic                any_pending;
  logic                ptr_upd;
  logic                do_grant;
  logic                wait_hit;
  logic                wait_to;

  pid_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .pending_i     (pending_q),
    .rr_ptr_i      (rr_ptr_q),
    .grant_o       (grant),
    .any_pending_o (any_pending),
    .ptr_upd_o     (ptr_upd)
  );

  assign do_grant = (state_q == S_IDLE) && any_pending;
  assign wait_hit = (state_q == S_WAIT) && core_done;
  assign wait_to  = (state_q == S_WAIT) && !core_done && (cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_pending) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT:   if (wait_hit || wait_to) state_d = wait_hit ? S_REPORT : S_IDLE;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    core_start = (state_q == S_ISSUE);
    out_valid  = (state_q == S_REPORT);
    busy       = (state_q != S_IDLE);
  end

  // New requests are ORed in after the issue-time clear, so a re-request of the active channel survives.
  always_comb begin
    pending_d = pending_q;
    if (state_q == S_ISSUE) begin
      pending_d[core_ch_q] = 1'b0;
    end
    pending_d = pending_d | ch_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      rr_ptr_q   <= CH_W'(NUM_CH - 1);
      core_ch_q  <= '0;
      core_sp_q  <= '0;
      core_fb_q  <= '0;
      out_ch_q   <= '0;
      out_data_q <= '0;
      timeout_q  <= '0;
      cnt_q      <= '0;
    end else begin
      pending_q <= pending_d;
      if (do_grant) begin
        if (ptr_upd) begin
          rr_ptr_q <= grant;
        end
        core_ch_q <= grant;
        core_sp_q <= lane_of(PID_BUS_W'(ch_setpoint), PID_IDX_W'(grant));
        core_fb_q <= lane_of(PID_BUS_W'(ch_feedback), PID_IDX_W'(grant));
      end
      if (state_q == S_ISSUE) begin
        cnt_q <= '0;
      end else if ((state_q == S_WAIT) && !wait_to) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (wait_hit) begin
        out_data_q <= core_result;
        out_ch_q   <= core_ch_q;
      end
      if (wait_to) begin
        timeout_q[core_ch_q] <= 1'b1;
      end
    end
  end

  assign core_ch       = core_ch_q;
  assign core_setpoint = core_sp_q;
  assign core_feedback = core_fb_q;
  assign out_ch        = out_ch_q;
  assign out_data      = out_data_q;
  assign timeout_err   = timeout_q;

endmodule
